div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_core_iter.sv | 88 ++++++++
 rtl/div_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_div_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the divider scheduler slice.
//               Holds the FSM state encoding, the sign-extended quotient
//               width, the rsp_error bit positions and the default operand
//               width.
// Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

   localparam int DEF_WIDTH = 16;   // default operand width
   localparam int QWIDTH    = 32;   // width of the sign-extended quotient port
   localparam int ERR_DIV0  = 1;    // rsp_error bit: divide-by-zero
   localparam int ERR_RSVD  = 0;    // rsp_error bit: reserved, always 0

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_core_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_core_iter
// Description : Unsigned restoring divider datapath, one quotient bit per
//               step. The quotient register starts out holding the dividend
//               and shifts quotient bits in from the right as dividend bits
//               leave on the left.
// Ports       : clk, rst_n      clock, async active-low reset
//               load_i          capture operand magnitudes, clear counter
//               step_i          perform one shift-subtract step
//               dividend_i      dividend magnitude (unsigned)
//               divisor_i       divisor magnitude (unsigned, nonzero)
//               quotient_o      quotient magnitude
//               remainder_o     remainder magnitude
//               last_o          the current step is the final one
// Revision    : 1.0  initial release
// ============================================================================
module div_core_iter
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             last_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Partial remainder shifted left with the next dividend bit appended.
   // The top bit matters only for the compare; the difference is always
   // smaller than the divisor, so WIDTH bits of it suffice.
   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;

   assign w_shift = {rem_q, quo_q[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, dvs_q});
   assign w_diff  = w_shift[WIDTH-1:0] - dvs_q;

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      if (load_i) begin
         rem_d = '0;
         quo_d = dividend_i;
         dvs_d = divisor_i;
         cnt_d = '0;
      end else if (step_i) begin
         rem_d = w_ge ? w_diff : w_shift[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], w_ge};
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign last_o      = (cnt_q == CW'(WIDTH - 1));

endmodule : div_core_iter
`default_nettype wire

// File: rtl/div_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : div_scheduler
// Description : Round-robin front end for a single iterative signed divider.
//               One operation is in flight at a time: IDLE grants one
//               requester, CALC runs WIDTH unsigned steps, FIX applies the
//               signs, DONE holds the result until it is consumed. A zero
//               divisor skips straight to DONE with an error flag.
// Ports       : clk, rst_n                  clock, async active-low reset
//               req_valid/req_ready [NREQ]   per-requester handshake
//               req_dividend/req_divisor     NREQ packed signed operands
//               rsp_valid/rsp_ready          result handshake
//               rsp_id                       owning requester
//               rsp_quotient                 signed quotient, 32 bits
//               rsp_remainder                signed remainder
//               rsp_error                    bit 1 = divide-by-zero
// Revision    : 1.0  initial release
// ============================================================================
module div_scheduler
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = 2,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_dividend,
   input  logic [NREQ*WIDTH-1:0] req_divisor,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [QWIDTH-1:0]     rsp_quotient,
   output logic [WIDTH-1:0]      rsp_remainder,
   output logic [1:0]            rsp_error
);

   state_e            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;      // highest-priority requester
   logic [IDW-1:0]    id_q, id_d;
   logic [QWIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic [1:0]        err_q, err_d;
   logic              negq_q, negq_d;    // quotient must be negated
   logic              negr_q, negr_d;    // remainder must be negated

   logic              w_found;
   logic [IDW-1:0]    w_gidx;
   logic [WIDTH-1:0]  w_sel_dvd;
   logic [WIDTH-1:0]  w_sel_dvs;
   logic [WIDTH-1:0]  w_dvd_mag;
   logic [WIDTH-1:0]  w_dvs_mag;
   logic              w_accept;
   logic              w_core_load;
   logic              w_core_step;
   logic [WIDTH-1:0]  w_core_quo;
   logic [WIDTH-1:0]  w_core_rem;
   logic              w_core_last;
   logic [QWIDTH-1:0] w_quo_ext;

   // Round-robin winner: first valid at or above the pointer, otherwise
   // wrap around to the first valid from index 0.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req_valid[i] && (IDW'(i) >= ptr_q)) begin
            w_found = 1'b1;
            w_gidx  = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req_valid[i]) begin
            w_found = 1'b1;
            w_gidx  = IDW'(i);
         end
      end
   end

   always_comb begin
      w_sel_dvd = '0;
      w_sel_dvs = '0;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gidx == IDW'(i)) begin
            w_sel_dvd = req_dividend[i*WIDTH +: WIDTH];
            w_sel_dvs = req_divisor[i*WIDTH +: WIDTH];
         end
         req_ready[i] = (state_q == ST_IDLE) && w_found && (w_gidx == IDW'(i));
      end
   end

   assign w_accept  = (state_q == ST_IDLE) && w_found;
   // Unsigned magnitude: the most negative value maps to 2^(WIDTH-1).
   assign w_dvd_mag = w_sel_dvd[WIDTH-1] ? (-w_sel_dvd) : w_sel_dvd;
   assign w_dvs_mag = w_sel_dvs[WIDTH-1] ? (-w_sel_dvs) : w_sel_dvs;
   assign w_quo_ext = QWIDTH'(w_core_quo);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      quo_d       = quo_q;
      rem_d       = rem_q;
      err_d       = err_q;
      negq_d      = negq_q;
      negr_d      = negr_q;
      w_core_load = 1'b0;
      w_core_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               ptr_d  = (w_gidx == IDW'(NREQ - 1)) ? '0 : (w_gidx + 1'b1);
               id_d   = w_gidx;
               negq_d = w_sel_dvd[WIDTH-1] ^ w_sel_dvs[WIDTH-1];
               negr_d = w_sel_dvd[WIDTH-1];
               err_d  = '0;
               if (w_sel_dvs == '0) begin
                  state_d         = ST_DONE;
                  quo_d           = '0;
                  rem_d           = w_sel_dvd;
                  err_d[ERR_DIV0] = 1'b1;
               end else begin
                  state_d     = ST_CALC;
                  w_core_load = 1'b1;
               end
            end
         end
         ST_CALC: begin
            w_core_step = 1'b1;
            if (w_core_last) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            quo_d   = negq_q ? (-w_quo_ext) : w_quo_ext;
            rem_d   = negr_q ? (-w_core_rem) : w_core_rem;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         err_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
      end
   end

   div_core_iter #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (w_core_load),
      .step_i      (w_core_step),
      .dividend_i  (w_dvd_mag),
      .divisor_i   (w_dvs_mag),
      .quotient_o  (w_core_quo),
      .remainder_o (w_core_rem),
      .last_o      (w_core_last)
   );

   // Result fields read as zero whenever no response is presented.
   assign rsp_valid     = (state_q == ST_DONE);
   assign rsp_id        = rsp_valid ? id_q  : '0;
   assign rsp_quotient  = rsp_valid ? quo_q : '0;
   assign rsp_remainder = rsp_valid ? rem_q : '0;
   assign rsp_error     = rsp_valid ? err_q : '0;

endmodule : div_scheduler
`default_nettype wire

// File: tb/tb_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_scheduler
// Description : Scoreboard bench for div_scheduler. Accepted requests push
//               the arithmetically expected response; a negedge monitor pops
//               and compares whenever a response is consumed. Latency is
//               counted in edges, including the accepting edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_div_scheduler;

   localparam int WIDTH = 16;
   localparam int NREQ  = 2;
   localparam int IDW   = 1;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_dividend = '0;
   logic [NREQ*WIDTH-1:0] req_divisor = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b1;
   logic [IDW-1:0]        rsp_id;
   logic [31:0]           rsp_quotient;
   logic [WIDTH-1:0]      rsp_remainder;
   logic [1:0]            rsp_error;

   div_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_quotient  (rsp_quotient),
      .rsp_remainder (rsp_remainder),
      .rsp_error     (rsp_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IDW-1:0]   id;
      logic [31:0]      q;
      logic [WIDTH-1:0] r;
      logic [1:0]       err;
      int               acc_edge;
      int               lat;
   } exp_t;

   exp_t        sb_q[$];
   int          tests = 0;
   int          fails = 0;
   int          edge_cnt = 0;
   int          acc_cnt [NREQ] = '{default: 0};
   int          seen    [NREQ] = '{default: 0};
   int          seen_tot = 0;
   int          last_gnt = NREQ - 1;
   int          to_cnt = 0;
   int          to_seen = 0;
   bit          head_seen = 1'b0;
   bit          hold = 1'b0;
   logic [50:0] snap = '0;
   bit          fin_req = 1'b0;
   bit          fin_done = 1'b0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Requester after the last-granted one has priority.
   function automatic int winner(logic [NREQ-1:0] v, int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   // Plain signed integer division (truncates toward zero).
   function automatic exp_t ref_model(int id, logic signed [WIDTH-1:0] a,
                                      logic signed [WIDTH-1:0] b, int acc);
      exp_t e;
      int   ai = a;
      int   bi = b;
      int   q;
      int   r;
      if (bi == 0) begin
         q = 0; r = ai; e.err = 2'b10; e.lat = 1;
      end else begin
         q = ai / bi; r = ai % bi; e.err = 2'b00; e.lat = WIDTH + 2;
      end
      e.id = id[IDW-1:0];
      e.q = q;
      e.r = r[WIDTH-1:0];
      e.acc_edge = acc;
      return e;
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      check("no_timeout", to_cnt, to_seen);
      to_seen = to_cnt;
      if (!rst_n) begin
         sb_q.delete();
         last_gnt  = NREQ - 1;
         head_seen = 1'b0;
         hold      = 1'b0;
         check("reset_rsp_valid", rsp_valid, 0);
         check("reset_req_ready", req_ready, 0);
         check("reset_rsp_fields", {rsp_id, rsp_quotient, rsp_remainder, rsp_error}, 0);
      end else begin
         if (req_ready != '0) check("ready_onehot", $countones(req_ready), 1);
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               check("grant_id", i, winner(req_valid, last_gnt));
               last_gnt = i;
               acc_cnt[i]++;
               sb_q.push_back(ref_model(i, req_dividend[i*WIDTH +: WIDTH],
                                        req_divisor[i*WIDTH +: WIDTH], edge_cnt + 1));
            end
         end
         if (!rsp_valid) begin
            check("idle_rsp_zero", {rsp_id, rsp_quotient, rsp_remainder, rsp_error}, 0);
            hold = 1'b0;
         end else begin
            check("ready_low_in_done", req_ready, 0);
            check("rsp_has_expect", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               e = sb_q[0];
               if (!head_seen) begin
                  check("latency", edge_cnt - e.acc_edge + 1, e.lat);
                  head_seen = 1'b1;
               end
               if (hold) check("hold_stable", {rsp_id, rsp_quotient, rsp_remainder, rsp_error}, snap);
               check("rsp_id", rsp_id, e.id);
               check("rsp_quotient", rsp_quotient, e.q);
               check("rsp_remainder", rsp_remainder, e.r);
               check("rsp_error", rsp_error, e.err);
               if (rsp_ready) begin
                  void'(sb_q.pop_front());
                  head_seen = 1'b0;
                  hold = 1'b0;
               end else begin
                  hold = 1'b1;
                  snap = {rsp_id, rsp_quotient, rsp_remainder, rsp_error};
               end
            end
         end
      end
      if (fin_req && !fin_done) begin
         check("scoreboard_drained", sb_q.size(), 0);
         fin_done = 1'b1;
      end
   end

   // Stimulus
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acc_cnt[i] != seen[i]) begin
            seen[i] = acc_cnt[i];
            seen_tot++;
            req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic issue(int id, int a, int b);
      req_dividend[id*WIDTH +: WIDTH] = a[WIDTH-1:0];
      req_divisor[id*WIDTH +: WIDTH]  = b[WIDTH-1:0];
      req_valid[id] = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((req_valid != '0 || sb_q.size() != 0) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) to_cnt++;
   endtask

   task automatic wait_accept(int id);
      int n = 0;
      while (req_valid[id] && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) to_cnt++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      repeat (2) tick();
      for (int i = 0; i < NREQ; i++) seen[i] = acc_cnt[i];
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      int a;
      int b;
      repeat (3) tick();
      rst_n = 1'b1;

      // Basic signed cases; first request arrives on the first edge out of reset
      issue(0, 53, 3);          wait_idle();
      issue(1, -53, 3);         wait_idle();
      issue(1, -32768, -1);     wait_idle();
      issue(0, 16, 0);          wait_idle();
      issue(0, -16, 0);         wait_idle();

      // Simultaneous pair after reset, then requester 0 re-raised while 1 waits
      do_reset();
      issue(0, 8793, 55);
      issue(1, 16, -2);
      wait_accept(0);
      issue(0, 8793, 55);
      wait_idle();

      // Back-pressure in DONE with another requester waiting
      rsp_ready = 1'b0;
      issue(0, 1000, 7);
      n = 0;
      while (!rsp_valid && n < 100) begin tick(); n++; end
      if (n >= 100) to_cnt++;
      issue(1, 5, 5);
      repeat (5) tick();
      rsp_ready = 1'b1;
      wait_idle();

      // Reset during CALC aborts; fresh request afterwards
      issue(0, 1234, 7);
      wait_accept(0);
      repeat (7) tick();
      do_reset();
      issue(0, 16, 1);
      wait_idle();

      // Randomized traffic
      n = 0;
      while (seen_tot < 80 && n < 5000) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               a = int'($urandom_range(0, 65535)) - 32768;
               b = int'($urandom_range(0, 65535)) - 32768;
               case ($urandom_range(0, 9))
                  0: b = 0;
                  1: a = -32768;
                  2: b = -1;
                  3: b = int'($urandom_range(1, 20));
                  default: ;
               endcase
               issue(i, a, b);
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end
      if (n >= 5000) to_cnt++;
      rsp_ready = 1'b1;
      wait_idle();

      fin_req = 1'b1;
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_div_scheduler
`default_nettype wire
